csr_access_unit: RTL

Initiator side of the CSR register-file interface: accepts one CSR instruction (csrrd / csrwr / csrxchg) from the execute stage and reads the addressed CSR. For write-type operations it issues a single-cycle write request, then returns the old CSR value for the destination GPR. It sits between the execute stage and the CSR register file and owns the read-address port and the write-request port of that file.

---
 rtl/csr_access_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR register-file interface.
// Runs one csrrd / csrwr / csrxchg at a time through IDLE -> READ ->
// (WRITE) -> RESP. It returns the old CSR value for the destination GPR.
module csr_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [CSR_ADDR_WIDTH-1:0] req_csr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH-1:0]     req_mask,
  input  logic [4:0]                req_rd_idx,
  input  logic                      flush,
  output logic [CSR_ADDR_WIDTH-1:0] csr_r_addr,
  input  logic [DATA_WIDTH-1:0]     csr_r_data,
  output logic                      csr_rw_en,
  output logic [CSR_ADDR_WIDTH-1:0] csr_rw_addr,
  output logic [DATA_WIDTH-1:0]     csr_rw_data,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [4:0]                resp_rd_idx,
  output logic [DATA_WIDTH-1:0]     resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  state_t                    state_r;
  logic [1:0]                op_r;
  logic [CSR_ADDR_WIDTH-1:0] csr_r;
  logic [DATA_WIDTH-1:0]     wdata_r;
  logic [DATA_WIDTH-1:0]     mask_r;
  logic [4:0]                idx_r;
  logic [DATA_WIDTH-1:0]     old_r;

  // Bitwise exchange: mask bits take the new value, other bits keep the old one.
  function automatic logic [DATA_WIDTH-1:0] xchg_merge(
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (new_val & mask) | (old_val & ~mask);
  endfunction

  // Control FSM and request/old-value latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      op_r    <= OP_RD;
      csr_r   <= '0;
      wdata_r <= '0;
      mask_r  <= '0;
      idx_r   <= 5'd0;
      old_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && !flush) begin
            // The reserved encoding behaves exactly like a plain read.
            op_r    <= (req_op == OP_RSVD) ? OP_RD : req_op;
            csr_r   <= req_csr;
            wdata_r <= req_wdata;
            mask_r  <= req_mask;
            idx_r   <= req_rd_idx;
            state_r <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (flush) begin
            state_r <= IDLE;
          end else begin
            old_r   <= csr_r_data;
            state_r <= (op_r == OP_RD) ? RESP : WRITE;
          end
        end
        WRITE: begin
          state_r <= flush ? IDLE : RESP;
        end
        RESP: begin
          if (flush || resp_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output decode from state. The write strobe is also gated by flush so a flush
  // that arrives during WRITE prevents the write in the same cycle.
  always_comb begin
    req_ready   = 1'b0;
    csr_rw_en   = 1'b0;
    csr_rw_addr = '0;
    csr_rw_data = '0;
    resp_valid  = 1'b0;
    csr_r_addr  = csr_r;
    resp_data   = old_r;
    resp_rd_idx = idx_r;
    case (state_r)
      IDLE: begin
        req_ready = !rst;
      end
      READ: begin
        req_ready = 1'b0;
      end
      WRITE: begin
        csr_rw_en   = !flush;
        csr_rw_addr = csr_r;
        case (op_r)
          OP_XCHG: csr_rw_data = xchg_merge(wdata_r, old_r, mask_r);
          OP_WR:   csr_rw_data = wdata_r;
          default: csr_rw_data = wdata_r;
        endcase
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule
